// File: rtl/fpu_share_pkg.sv
// Shared types for the fpnew sharing arbiter.
// Enumerations reuse the fpnew_pkg encodings, so fpu_req_t lines up bit-for-bit
// with the operand/op/format inputs of fpnew_top.
package fpu_share_pkg;

  localparam int unsigned FP_WIDTH     = 16;
  localparam int unsigned STATUS_W     = 5;
  localparam int unsigned NUM_OPERANDS = 3;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
    RMM = 3'b100, ROD = 3'b101, DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4, FP8ALT = 3'd5
  } fp_format_e;

  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

  typedef enum logic [1:0] {IDLE, LOCK, FLUSH} state_e;

  typedef struct packed {
    logic [NUM_OPERANDS-1:0][FP_WIDTH-1:0] operands;
    operation_e                            op;
    logic                                  op_mod;
    roundmode_e                            rnd_mode;
    fp_format_e                            src_fmt;
    fp_format_e                            dst_fmt;
    int_format_e                           int_fmt;
  } fpu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i.
// Ports: req_i request vector, ptr_i priority start index,
//        gnt_o one-hot grant, idx_o grant index, valid_o any request present.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Walk the requesters starting at the pointer, wrapping at N.
  always_comb begin
    int unsigned      w_pos;
    logic [IDX_W-1:0] w_idx;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_pos   = 0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_pos = 32'(ptr_i) + i;
      if (w_pos >= N) w_pos = w_pos - N;
      w_idx = IDX_W'(w_pos);
      if (!valid_o && req_i[w_idx]) begin
        valid_o      = 1'b1;
        gnt_o[w_idx] = 1'b1;
        idx_o        = w_idx;
      end
    end
  end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one fpnew_top between NUM_REQ requesters.
// Requests are granted round-robin, one at a time, with the requester index
// carried in the FPU tag; results are steered back by tag. An outstanding-op
// credit counter caps in-flight work, and flush_i drains the FPU.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i abort pulse;
//        req_* client request side; fpu_* fpnew_top in/out handshakes;
//        rsp_* client result side (shared result/status bus, one-hot valid).
module fpu_share_arbiter
  import fpu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned WIDTH     = FP_WIDTH,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned TAG_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  fpu_req_t [NUM_REQ-1:0]    req_i,
  output fpu_req_t                  fpu_req_o,
  output logic [TAG_W-1:0]          fpu_tag_o,
  output logic                      fpu_in_valid_o,
  input  logic                      fpu_in_ready_i,
  output logic                      fpu_flush_o,
  input  logic [WIDTH-1:0]          fpu_result_i,
  input  logic [STATUS_W-1:0]       fpu_status_i,
  input  logic [TAG_W-1:0]          fpu_tag_i,
  input  logic                      fpu_out_valid_i,
  output logic                      fpu_out_ready_o,
  input  logic                      fpu_busy_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [WIDTH-1:0]          rsp_result_o,
  output logic [STATUS_W-1:0]       rsp_status_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  state_e             r_state, w_state_nxt;
  logic [TAG_W-1:0]   r_grant;
  logic [TAG_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_outst_cnt;
  fpu_req_t           r_fpu_req;
  logic               r_flush;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [TAG_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  fpu_req_t           w_sel_req;
  logic               w_credit_ok;
  logic               w_grant_load;
  logic               w_issue;
  logic               w_tag_bad;
  logic               w_rsp_hs;
  logic [TAG_W-1:0]   w_ptr_nxt;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (r_rr_ptr),
    .gnt_o   (w_arb_gnt),
    .idx_o   (w_arb_idx),
    .valid_o (w_arb_valid)
  );

  // One-hot payload select for the winning requester.
  always_comb begin
    w_sel_req = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_arb_gnt[k]) w_sel_req = req_i[k];
    end
  end

  assign w_credit_ok = (32'(r_outst_cnt) < MAX_OUTST);
  assign w_tag_bad   = (32'(fpu_tag_i) >= NUM_REQ);
  assign w_ptr_nxt   = (32'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + TAG_W'(1);

  // Next state, grant load and issue strobe; flush_i overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_load = 1'b0;
    w_issue      = 1'b0;
    req_ready_o  = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid && w_credit_ok) begin
          w_state_nxt  = LOCK;
          w_grant_load = 1'b1;
        end
      end
      LOCK: begin
        req_ready_o[r_grant] = fpu_in_ready_i;
        if (fpu_in_ready_i) begin
          w_state_nxt = IDLE;
          w_issue     = 1'b1;
        end
      end
      FLUSH: begin
        if (!fpu_busy_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt  = FLUSH;
      w_grant_load = 1'b0;
      w_issue      = 1'b0;
    end
  end

  // Result steering by tag; while draining, or for a bogus tag, results are discarded.
  always_comb begin
    rsp_valid_o     = '0;
    fpu_out_ready_o = 1'b0;
    if (r_state == FLUSH || w_tag_bad) begin
      fpu_out_ready_o = 1'b1;
    end else begin
      rsp_valid_o[fpu_tag_i] = fpu_out_valid_i;
      fpu_out_ready_o        = rsp_ready_i[fpu_tag_i];
    end
  end

  assign w_rsp_hs = fpu_out_valid_i && fpu_out_ready_o && !w_tag_bad && (r_state != FLUSH);

  // State, grant, pointer, credit counter and flush pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_outst_cnt <= '0;
      r_fpu_req   <= '0;
      r_flush     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= flush_i;
      if (flush_i) begin
        r_grant <= '0;
      end else if (w_grant_load) begin
        r_grant   <= w_arb_idx;
        r_fpu_req <= w_sel_req;
      end
      if (w_issue) r_rr_ptr <= w_ptr_nxt;
      if (flush_i) begin
        r_outst_cnt <= '0;
      end else if (w_issue && !w_rsp_hs) begin
        r_outst_cnt <= r_outst_cnt + CNT_W'(1);
      end else if (!w_issue && w_rsp_hs && (r_outst_cnt != '0)) begin
        r_outst_cnt <= r_outst_cnt - CNT_W'(1);
      end
    end
  end

  assign fpu_in_valid_o = (r_state == LOCK);
  assign fpu_req_o      = r_fpu_req;
  assign fpu_tag_o      = r_grant;
  assign fpu_flush_o    = r_flush;
  assign rsp_result_o   = fpu_result_i;
  assign rsp_status_o   = fpu_status_i;

  // A tag the arbiter never issued means the FPU returned something foreign.
  a_tag_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fpu_out_valid_i && w_tag_bad))
    else $error("fpu_share_arbiter: result tag %0d out of range, dropped", fpu_tag_i);

endmodule
